// File: rtl/cmd_dispatch_pkg.sv
// Shared types for the command dispatcher:
// command opcodes and FSM states.
package cmd_dispatch_pkg;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_WRITE,
    OP_READ,
    OP_INC
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_RESP
  } state_e;

endpackage

// File: rtl/cmd_dispatch.sv
// Command dispatcher: decodes host commands into channel
// register writes, read responses and increment bursts.
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 2,
  parameter int IDX_W  = $clog2(NUM_CH),
  parameter int CH_W   = IDX_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CH_W-1:0]          cmd_ch,
  input  logic [DATA_W-1:0]        cmd_data,
  input  logic [LEN_W-1:0]         cmd_len,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     err,
  output logic [NUM_CH*DATA_W-1:0] ch_reg
);

  state_e              r_state;
  logic [LEN_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_ch;
  logic [DATA_W-1:0]   r_regs [NUM_CH];
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_err;

  state_e              w_state_nxt;
  logic [LEN_W-1:0]    w_cnt_nxt;
  logic [IDX_W-1:0]    w_ch_nxt;
  logic                w_we;
  logic [IDX_W-1:0]    w_widx;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_rv_nxt;
  logic [DATA_W-1:0]   w_rd_nxt;
  logic                w_err_nxt;

  logic                w_accept;
  logic                w_ch_ok;
  logic [IDX_W-1:0]    w_idx;
  op_e                 w_op;

  assign cmd_ready = (r_state == S_IDLE);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_ch_ok   = (cmd_ch < CH_W'(NUM_CH));
  assign w_idx     = cmd_ch[IDX_W-1:0];
  assign w_op      = op_e'(cmd_op);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_we        = 1'b0;
    w_widx      = r_ch;
    w_wdata     = '0;
    w_rv_nxt    = r_rsp_valid;
    w_rd_nxt    = r_rsp_data;
    w_err_nxt   = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (w_accept) begin
          // Out-of-range channel swallows any op.
          if (!w_ch_ok) begin
            w_err_nxt = 1'b1;
          end else begin
            unique case (w_op)
              OP_NOP: ;
              OP_WRITE: begin
                w_we    = 1'b1;
                w_widx  = w_idx;
                w_wdata = cmd_data;
              end
              OP_READ: begin
                w_rv_nxt    = 1'b1;
                w_rd_nxt    = r_regs[w_idx];
                w_state_nxt = S_RESP;
              end
              OP_INC: begin
                w_cnt_nxt   = cmd_len;
                w_ch_nxt    = w_idx;
                w_state_nxt = S_BURST;
              end
            endcase
          end
        end
      end
      (r_state == S_BURST): begin
        w_we    = 1'b1;
        w_widx  = r_ch;
        w_wdata = r_regs[r_ch] + DATA_W'(1);
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - LEN_W'(1);
        end
      end
      (r_state == S_RESP): begin
        if (rsp_ready) begin
          w_rv_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ch        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ch        <= w_ch_nxt;
      r_rsp_valid <= w_rv_nxt;
      r_rsp_data  <= w_rd_nxt;
      r_err       <= w_err_nxt;
      if (w_we) begin
        r_regs[w_widx] <= w_wdata;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign err       = r_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign ch_reg[g*DATA_W +: DATA_W] = r_regs[g];
  end

endmodule
